// File: rtl/uo_arb_pkg.sv
// Shared types and width helpers for the uo_out port arbiter.
package uo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_HOLD
  } arb_state_e;

  function automatic int unsigned cnt_width(input int unsigned hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

  function automatic int unsigned owner_width(input int unsigned n_req);
    return $clog2(n_req);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after index last_i, wrapping.
module rr_picker
  import uo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned OW    = owner_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_masked_i,
  input  logic [OW-1:0]    last_i,
  output logic             any_o,
  output logic [OW-1:0]    idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  logic [OW-1:0] pos;

  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    pos      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      pos = OW'((32'(last_i) + k) % N_REQ);
      if (!any_o && req_masked_i[pos]) begin
        any_o = 1'b1;
        idx_o = pos;
      end
    end
    onehot_o[idx_o] = any_o;
  end

endmodule

// File: rtl/uo_port_arbiter.sv
// Round-robin arbiter sharing the dedicated output port; each granted word is
// held on the port for HOLD_CYCLES cycles before the next arbitration.
module uo_port_arbiter
  import uo_arb_pkg::*;
#(
  parameter int unsigned   N_REQ       = 4,
  parameter int unsigned   DW          = 8,
  parameter int unsigned   HOLD_CYCLES = 4,
  parameter logic [DW-1:0] IDLE_VALUE  = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_REQ-1:0]               req_i,
  input  logic [N_REQ*DW-1:0]            data_i,
  output logic [N_REQ-1:0]               gnt_o,
  output logic [DW-1:0]                  port_out_o,
  output logic                           port_oe_o,
  output logic                           busy_o,
  output logic [owner_width(N_REQ)-1:0]  owner_o
);

  localparam int unsigned   OW      = owner_width(N_REQ);
  localparam int unsigned   CW      = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] CntLoad = CW'(HOLD_CYCLES - 1);
  localparam logic [OW-1:0] LastRst = OW'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    port_q, port_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             arb_event;
  logic [N_REQ-1:0] req_masked;
  logic             win_any;
  logic [OW-1:0]    win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [DW-1:0]    words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = data_i[i*DW +: DW];
  end

  assign arb_event = (state_q == ST_IDLE) || (cnt_q == '0);
  // gnt_q is only ever set for the owner; drop its stale level in the grant cycle.
  assign req_masked = req_i & ~gnt_q;

  rr_picker #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_picker (
    .req_masked_i (req_masked),
    .last_i       (last_q),
    .any_o        (win_any),
    .idx_o        (win_idx),
    .onehot_o     (win_onehot)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      port_q  <= IDLE_VALUE;
      owner_q <= '0;
      last_q  <= LastRst;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (arb_event) begin
      state_d = win_any ? ST_HOLD : ST_IDLE;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    port_d  = port_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = '0;
    if (arb_event) begin
      if (win_any) begin
        cnt_d   = CntLoad;
        port_d  = words[win_idx];
        owner_d = win_idx;
        last_d  = win_idx;
        gnt_d   = win_onehot;
      end else begin
        cnt_d  = '0;
        port_d = IDLE_VALUE;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign gnt_o      = gnt_q;
  assign port_out_o = port_q;
  assign port_oe_o  = (state_q == ST_HOLD);
  assign busy_o     = (state_q == ST_HOLD);
  assign owner_o    = owner_q;

endmodule
